// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads imem over req/ack and
// hands each 16-bit word to decode over valid/ready, steering on branches.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              is_branch,
    input  logic [3:0]        branch_type,
    input  logic [15:0]       branch_offset,
    input  logic              zero_flag,
    output logic [15:0]       retired_count,
    output logic              fetch_error
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    localparam logic [3:0] BR_JUMP = 4'b1001;
    localparam logic [3:0] BR_BRZ  = 4'b1010;
    localparam logic [3:0] BR_BRNZ = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       retired_q, retired_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic              taken;
    logic [ADDR_W-1:0] next_pc;
    logic [WAIT_W-1:0] wait_inc;

    // Only the low ADDR_W offset bits matter; the PC wraps.
    logic unused_offset;
    assign unused_offset = ^branch_offset;

    always_comb begin
        taken = is_branch &
                ((branch_type == BR_JUMP) |
                 ((branch_type == BR_BRZ) & zero_flag) |
                 ((branch_type == BR_BRNZ) & ~zero_flag));
        if (taken) begin
            next_pc = instr_pc_q + branch_offset[ADDR_W-1:0];
        end else begin
            next_pc = instr_pc_q + ADDR_W'(1);
        end
        wait_inc = wait_q + WAIT_W'(1);

        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        instr_d    = instr_q;
        retired_d  = retired_q;
        wait_d     = wait_q;

        unique case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (enable) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    wait_d     = '0;
                    state_d    = S_ISSUE;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_MAX) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    retired_d = retired_q + 16'd1;
                    pc_d      = next_pc;
                    wait_d    = '0;
                    state_d   = enable ? S_FETCH : S_IDLE;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d   = (state_d == S_FETCH);
        valid_d = (state_d == S_ISSUE);
        err_d   = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_pc_q <= '0;
            instr_q    <= '0;
            retired_q  <= '0;
            wait_q     <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            instr_q    <= instr_d;
            retired_q  <= retired_d;
            wait_q     <= wait_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign instr_pc      = instr_pc_q;
    assign instr_valid   = valid_q;
    assign retired_count = retired_q;
    assign fetch_error   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory responder, a decode
// stand-in, and negedge monitors checking fetch addresses and issued words.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        is_branch;
    logic [3:0]  branch_type;
    logic [15:0] branch_offset;
    logic        zero_flag;
    logic [15:0] retired_count;
    logic        fetch_error;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .is_branch(is_branch), .branch_type(branch_type),
        .branch_offset(branch_offset), .zero_flag(zero_flag),
        .retired_count(retired_count), .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    // Decode stand-in: opcodes 8..F flag a branch, 12-bit signed offset.
    assign is_branch     = instr[15];
    assign branch_type   = instr[15:12];
    assign branch_offset = {{4{instr[11]}}, instr[11:0]};

    logic [15:0] mem [256];
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    int          ack_delay = 1;
    int          req_cnt = 0;
    bit          ack_block = 0;
    bit          ack_force = 0;
    bit          track = 0;
    logic        req_prev = 1'b0;
    logic [7:0]  addr_q [$];
    logic [23:0] iss_q [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: ack after ack_delay waiting cycles of req.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (ack_force) begin
                imem_ack   = 1'b1;
                imem_rdata = 16'hDEAD;
            end else if (imem_req && !ack_block) begin
                if (req_cnt >= ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                end else begin
                    imem_ack = 1'b0;
                end
                req_cnt++;
            end else begin
                imem_ack = 1'b0;
                req_cnt  = 0;
            end
        end
    end

    // Monitor: new fetch address and each accepted instruction.
    initial begin
        logic [7:0]  ea;
        logic [23:0] ei;
        forever begin
            @(negedge clk);
            if (track && rst_n) begin
                if (imem_req && !req_prev) begin
                    if (addr_q.size() == 0) begin
                        chk("fetch_unexpected", {56'h0, imem_addr}, 64'hFFFF);
                    end else begin
                        ea = addr_q.pop_front();
                        chk("fetch_addr", {56'h0, imem_addr}, {56'h0, ea});
                    end
                end
                if (instr_valid && instr_ready) begin
                    hs_count++;
                    if (iss_q.size() == 0) begin
                        chk("issue_unexpected", {40'h0, instr, instr_pc}, 64'hFFFF_FFFF);
                    end else begin
                        ei = iss_q.pop_front();
                        chk("issue", {40'h0, instr, instr_pc}, {40'h0, ei});
                    end
                end
            end
            req_prev = imem_req;
        end
    end

    task automatic wait_hs(input int n);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (hs_count >= n) return;
        end
        chk("hs_timeout", 64'(hs_count), 64'(n));
    endtask

    task automatic do_step(input logic [7:0] pc, input logic [15:0] w,
                           input logic z, input int n);
        zero_flag = z;
        addr_q.push_back(pc);
        iss_q.push_back({w, pc});
        wait_hs(n);
        chk("req_after_hs", {63'h0, imem_req}, 64'h1);
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[0]   = 16'h1123;
        mem[1]   = 16'h2123;
        mem[2]   = 16'h3123;
        mem[3]   = 16'h9007;
        mem[10]  = 16'h9FFC;
        mem[6]   = 16'h900E;
        mem[20]  = 16'hBFF8;
        mem[12]  = 16'h90EE;
        mem[250] = 16'h900A;
        mem[4]   = 16'h9001;
        mem[5]   = 16'hA014;
        mem[25]  = 16'h9FEC;
        mem[21]  = 16'h8005;
        mem[22]  = 16'h1777;

        rst_n = 1'b0;
        enable = 1'b0;
        instr_ready = 1'b1;
        zero_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {63'h0, imem_req}, 64'h0);
        chk("rst_valid_err", {62'h0, instr_valid, fetch_error}, 64'h0);
        chk("rst_regs", {instr, instr_pc, imem_addr, retired_count}, 64'h0);

        rst_n = 1'b1;
        track = 1;
        enable = 1'b1;
        do_step(8'd0, 16'h1123, 1'b0, 1);
        do_step(8'd1, 16'h2123, 1'b0, 2);
        do_step(8'd2, 16'h3123, 1'b0, 3);
        chk("retired_3", {48'h0, retired_count}, 64'd3);
        do_step(8'd3,   16'h9007, 1'b0, 4);
        do_step(8'd10,  16'h9FFC, 1'b0, 5);
        do_step(8'd6,   16'h900E, 1'b0, 6);
        do_step(8'd20,  16'hBFF8, 1'b0, 7);
        do_step(8'd12,  16'h90EE, 1'b0, 8);
        do_step(8'd250, 16'h900A, 1'b0, 9);
        do_step(8'd4,   16'h9001, 1'b0, 10);
        do_step(8'd5,   16'hA014, 1'b1, 11);
        do_step(8'd25,  16'h9FEC, 1'b0, 12);
        do_step(8'd5,   16'hA014, 1'b0, 13);

        // Back-pressure: word at pc 6 held for five cycles.
        instr_ready = 1'b0;
        addr_q.push_back(8'd6);
        iss_q.push_back({16'h900E, 8'd6});
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (instr_valid) got = 1;
        end
        chk("valid_seen", {63'h0, got}, 64'h1);
        for (int i = 0; i < 5; i++) begin
            chk("hold", {22'h0, instr_valid, imem_req, instr, instr_pc, retired_count},
                {22'h0, 1'b1, 1'b0, 16'h900E, 8'd6, 16'd13});
            @(posedge clk);
            #1;
        end
        instr_ready = 1'b1;
        wait_hs(14);

        // enable dropped mid-fetch: issue completes, then park.
        enable = 1'b0;
        zero_flag = 1'b1;
        addr_q.push_back(8'd20);
        iss_q.push_back({16'hBFF8, 8'd20});
        wait_hs(15);
        for (int i = 0; i < 4; i++) begin
            chk("parked", {46'h0, imem_req, instr_valid, retired_count}, {46'h0, 2'b00, 16'd15});
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
        do_step(8'd21, 16'h8005, 1'b0, 16);
        do_step(8'd22, 16'h1777, 1'b0, 17);
        track = 0;
        ack_block = 1;

        // Ack timeout after MAX_WAIT request cycles.
        repeat (14) @(posedge clk);
        #1;
        chk("wait_edge", {62'h0, imem_req, fetch_error}, {62'h0, 2'b10});
        @(posedge clk);
        #1;
        chk("timeout", {61'h0, imem_req, fetch_error, instr_valid}, {61'h0, 3'b010});
        repeat (3) @(posedge clk);
        #1;
        chk("sticky", {62'h0, imem_req, fetch_error}, {62'h0, 2'b01});

        enable = 1'b0;
        ack_block = 0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst2_flags", {61'h0, imem_req, instr_valid, fetch_error}, 64'h0);
        chk("rst2_regs", {instr, instr_pc, imem_addr, retired_count}, 64'h0);

        // Reset coinciding with an ack must not load the word.
        ack_delay = 2;
        enable = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (imem_ack) begin
                rst_n = 1'b0;
                got = 1;
            end
        end
        chk("ack_seen", {63'h0, got}, 64'h1);
        @(posedge clk);
        #1;
        chk("rst_ack", {38'h0, instr, instr_pc, imem_req, instr_valid},
            {38'h0, 16'h0, 8'h0, 2'b00});

        // Same-cycle ack: valid one cycle after ack.
        ack_delay = 0;
        instr_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("req0", {55'h0, imem_req, imem_addr}, {55'h0, 1'b1, 8'd0});
        @(posedge clk);
        #1;
        chk("fast_issue", {39'h0, instr_valid, instr, instr_pc}, {39'h0, 1'b1, 16'h1123, 8'd0});
        ack_force = 1;
        repeat (2) @(posedge clk);
        #1;
        ack_force = 0;
        chk("ack_ignored", {23'h0, instr_valid, instr, retired_count},
            {23'h0, 1'b1, 16'h1123, 16'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
